// File: rtl/sdram_arb.sv
// -----------------------------------------------------------------------------
// sdram_arb -- SDRAM command arbiter
//
// Purpose:
//   Decides which of three requesters (auto-refresh, write burst, read burst)
//   owns the SDRAM command sequencer. Refresh always wins in IDLE. A write/read
//   tie goes to write by default; when SDRAM_ARB_RR_EN is defined the tie
//   alternates round-robin instead. A grant lasts until the sequencer pulses
//   cmd_done. A watchdog forces the arbiter back to IDLE and raises a sticky
//   error if a grant lasts too long. Every grant is followed by at least one
//   IDLE cycle, which gives the bus its turnaround.
//
// Configuration macro:
//   SDRAM_ARB_RR_EN  defined   -> round-robin write/read tie break
//                    undefined -> fixed priority, write beats read
//
// Parameters:
//   TIMEOUT_CYC  maximum grant length without cmd_done; legal range 2..1023.
//                A grant that sees no cmd_done stays high for TIMEOUT_CYC-1
//                cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   init_done    in   SDRAM power-up init complete (level)
//   aref_req     in   auto-refresh request (level, held until granted)
//   wr_req       in   write-burst request (level, held until granted)
//   rd_req       in   read-burst request (level, held until granted)
//   cmd_done     in   one-cycle pulse: granted operation finished
//   aref_en      out  refresh grant (registered)
//   wr_en        out  write grant (registered)
//   rd_en        out  read grant (registered)
//   arb_state    out  registered state code (INIT=0 IDLE=1 AREF=2 WRITE=3 READ=4)
//   timeout_err  out  sticky watchdog error, cleared only by rst
//
// Handshake: each request is a level held by its requester. The request is
// consumed on the edge where the matching grant first rises. The grant is
// released on the edge after cmd_done is sampled high, or by the watchdog.
// -----------------------------------------------------------------------------
module sdram_arb #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       aref_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       cmd_done,
  output logic       aref_en,
  output logic       wr_en,
  output logic       rd_en,
  output logic [2:0] arb_state,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // The counter holds 0 on the first grant cycle. It therefore holds
  // TIMEOUT_CYC-2 on the last cycle a grant may stay high. That is the cycle
  // where the next increment would reach TIMEOUT_CYC-1.
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 2);

  state_t     r_state;
  state_t     w_next;
  logic [9:0] r_busy_cnt;
  logic       r_aref_en;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_timeout_err;
  logic       w_busy;
  logic       w_timeout;
  state_t     w_tie_pick;

  assign w_busy = (r_state == ST_AREF) || (r_state == ST_WRITE) ||
                  (r_state == ST_READ);

  // cmd_done on the watchdog cycle counts as a normal completion, so it
  // suppresses the timeout.
  assign w_timeout = w_busy && !cmd_done && (r_busy_cnt == TO_LAST);

`ifdef SDRAM_ARB_RR_EN
  // High when the last wr/rd grant went to read. It resets to "read", so the
  // first tie after reset goes to write.
  logic r_last_rd;

  assign w_tie_pick = r_last_rd ? ST_WRITE : ST_READ;

  // The pointer moves only when a write or read grant is actually issued.
  // Refresh grants leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_rd <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_next == ST_WRITE) begin
        r_last_rd <= 1'b0;
      end else if (w_next == ST_READ) begin
        r_last_rd <= 1'b1;
      end
    end
  end
`else
  assign w_tie_pick = ST_WRITE;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: begin
        // Requests and cmd_done are ignored until init completes.
        if (init_done) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (aref_req) begin
          w_next = ST_AREF;
        end else if (wr_req && rd_req) begin
          w_next = w_tie_pick;
        end else if (wr_req) begin
          w_next = ST_WRITE;
        end else if (rd_req) begin
          w_next = ST_READ;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // There is no preemption: only completion or the watchdog ends a
        // grant. Returning through IDLE gives the turnaround cycle.
        if (cmd_done || w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        // Codes 5-7 are unreachable in normal operation. They recover to IDLE.
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered grants
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aref_en <= (w_next == ST_AREF);
      r_wr_en   <= (w_next == ST_WRITE);
      r_rd_en   <= (w_next == ST_READ);
    end
  end

  // Busy counter. It is cleared in every non-busy state. Every grant is
  // entered from IDLE, so the counter starts at 0 on the first grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= 10'd0;
    end else if (w_busy) begin
      r_busy_cnt <= r_busy_cnt + 10'd1;
    end else begin
      r_busy_cnt <= 10'd0;
    end
  end

  // Sticky watchdog error. Arbitration continues normally while it is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign aref_en     = r_aref_en;
  assign wr_en       = r_wr_en;
  assign rd_en       = r_rd_en;
  assign arb_state   = r_state;
  assign timeout_err = r_timeout_err;

endmodule
